mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 89 ++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state, owner encoding and width defaults for mem_arbiter
package mem_arb_pkg;
    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;
    typedef enum logic [1:0] {IDLE, BUSY_C, BUSY_D} state_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_DBG = 1'b1} owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU (c_*), debug (d_*) and memory (m_*) handshake bundle
// slave: arbiter view (takes requests, returns done/rdata, drives memory strobe/owner)
// master: environment view (drives requests and memory responses)
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_done;
    logic [DW-1:0] c_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;
    logic          owner;
    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_done, c_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_done, d_rdata,
        output m_req, m_we, m_addr, m_wdata, owner,
        input  m_rdata, m_ack
    );
    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_done, c_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_done, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, owner,
        output m_rdata, m_ack
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between a CPU and a debug requester
// Ports: clk; reset_n (async, active-low); bus (mem_arbiter_if.slave): c_*/d_* requester
// handshakes with one-cycle done pulses and registered rdata, m_* memory access, owner grant.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);
    state_t        state_q;
    owner_t        owner_q;
    owner_t        last_q;
    logic          m_req_q;
    logic          m_we_q;
    logic          c_done_q;
    logic          d_done_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q;
    logic [DW-1:0] c_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          c_elig;
    logic          d_elig;
    logic          gnt_dbg;

    // A request still held during its own done cycle is the finished one, not a new one.
    always_comb begin
        c_elig  = bus.c_req && !c_done_q;
        d_elig  = bus.d_req && !d_done_q;
        gnt_dbg = d_elig && (!c_elig || last_q == OWN_CPU);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_CPU;
            last_q    <= OWN_DBG;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            c_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            c_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (c_elig || d_elig) begin
                        state_q   <= gnt_dbg ? BUSY_D : BUSY_C;
                        owner_q   <= gnt_dbg ? OWN_DBG : OWN_CPU;
                        m_req_q   <= 1'b1;
                        m_we_q    <= gnt_dbg ? bus.d_we : bus.c_we;
                        m_addr_q  <= gnt_dbg ? bus.d_addr : bus.c_addr;
                        m_wdata_q <= gnt_dbg ? bus.d_wdata : bus.c_wdata;
                    end
                end
                BUSY_C, BUSY_D: begin
                    if (bus.m_ack) begin
                        state_q  <= IDLE;
                        m_req_q  <= 1'b0;
                        m_we_q   <= 1'b0;
                        last_q   <= owner_q;
                        c_done_q <= state_q == BUSY_C;
                        d_done_q <= state_q == BUSY_D;
                        if (!m_we_q && state_q == BUSY_C) c_rdata_q <= bus.m_rdata;
                        if (!m_we_q && state_q == BUSY_D) d_rdata_q <= bus.m_rdata;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.owner   = owner_q;
    assign bus.c_done  = c_done_q;
    assign bus.d_done  = d_done_q;
    assign bus.c_rdata = c_rdata_q;
    assign bus.d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int lat_min = 1;
    int lat_max = 1;
    int age = 0;
    int cur_lat = 1;
    logic own_log[$];
    logic [31:0] phys [logic [31:0]];
    logic [31:0] mem_ref [logic [31:0]];

    mem_arbiter_if #(.AW(32), .DW(32)) bus();
    mem_arbiter #(.AW(32), .DW(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    // Memory responder: acks after lat cycles of m_req (lat=1 acks in the first m_req cycle).
    initial begin
        bus.m_ack = 1'b0;
        bus.m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n || bus.m_ack) begin
                bus.m_ack = 1'b0;
                age = 0;
            end else if (bus.m_req) begin
                if (age == 0) begin
                    own_log.push_back(bus.owner);
                    cur_lat = int'($urandom_range(lat_max, lat_min));
                end
                age++;
                if (age >= cur_lat) begin
                    bus.m_ack = 1'b1;
                    if (bus.m_we) phys[bus.m_addr] = bus.m_wdata;
                    else bus.m_rdata = phys.exists(bus.m_addr) ? phys[bus.m_addr] : 32'h0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1);
    end

    function automatic logic [31:0] ref_read(logic [31:0] a);
        return mem_ref.exists(a) ? mem_ref[a] : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.m_req, bus.m_we, bus.c_done, bus.d_done, bus.owner} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got req/we/cd/dd/own=%b want 00000",
                     {bus.m_req, bus.m_we, bus.c_done, bus.d_done, bus.owner});
        end
        checks++;
        if (bus.m_addr !== 32'h0) begin errors++; $display("FAIL reset_m_addr got %h want 0", bus.m_addr); end
        checks++;
        if (bus.m_wdata !== 32'h0) begin errors++; $display("FAIL reset_m_wdata got %h want 0", bus.m_wdata); end
        checks++;
        if (bus.c_rdata !== 32'h0) begin errors++; $display("FAIL reset_c_rdata got %h want 0", bus.c_rdata); end
        checks++;
        if (bus.d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata got %h want 0", bus.d_rdata); end
    endtask

    task automatic test_cpu_read();
        int cyc = 0;
        bit got = 0;
        bit dseen = 0;
        lat_min = 1; lat_max = 1;
        bus.c_we = 1'b0; bus.c_addr = 32'h40; bus.c_req = 1'b1;
        while (!got && cyc < 10) begin
            tick();
            cyc++;
            if (bus.d_done) dseen = 1;
            if (cyc == 1) begin
                checks++;
                if ({bus.m_req, bus.owner, bus.m_we} !== 3'b100 || bus.m_addr !== 32'h40) begin
                    errors++;
                    $display("FAIL cpu_read_issue got req/own/we=%b addr=%h want 100 addr=40",
                             {bus.m_req, bus.owner, bus.m_we}, bus.m_addr);
                end
            end
            if (bus.c_done) got = 1;
        end
        bus.c_req = 1'b0;
        repeat (3) begin tick(); if (bus.d_done || bus.c_done) dseen = 1; end
        checks++;
        if (!got || cyc != 2) begin errors++; $display("FAIL cpu_read_latency got %0d cycles want 2", cyc); end
        checks++;
        if (bus.c_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_read_data got %h want deadbeef", bus.c_rdata); end
        checks++;
        if (dseen) begin errors++; $display("FAIL cpu_read_stray_done got 1 want 0"); end
    endtask

    task automatic test_tie();
        int cd = 0;
        int dd = 0;
        logic [1:0] seq;
        do_reset();
        own_log.delete();
        lat_min = 3; lat_max = 3;
        bus.c_we = 1'b0; bus.c_addr = 32'h40;
        bus.d_we = 1'b0; bus.d_addr = 32'h40;
        bus.c_req = 1'b1; bus.d_req = 1'b1;
        repeat (30) begin
            tick();
            if (bus.c_done) begin cd++; bus.c_req = 1'b0; end
            if (bus.d_done) begin dd++; bus.d_req = 1'b0; end
        end
        seq = own_log.size() == 2 ? {own_log[0], own_log[1]} : 2'bxx;
        checks++;
        if (seq !== 2'b01) begin errors++; $display("FAIL tie_order got %b (n=%0d) want 01", seq, own_log.size()); end
        checks++;
        if (cd != 1 || dd != 1) begin errors++; $display("FAIL tie_dones got c=%0d d=%0d want 1 1", cd, dd); end
        checks++;
        if (bus.d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL tie_d_rdata got %h want deadbeef", bus.d_rdata); end
    endtask

    task automatic test_dbg_write();
        logic [31:0] prev = bus.d_rdata;
        bit got = 0;
        lat_min = 4; lat_max = 4;
        bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'h12345678; bus.d_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.m_req) begin
                checks++;
                if ({bus.m_we, bus.owner} !== 2'b11 || bus.m_addr !== 32'h100 || bus.m_wdata !== 32'h12345678) begin
                    errors++;
                    $display("FAIL dbg_write_hold got we/own=%b addr=%h wdata=%h want 11 addr=100 wdata=12345678",
                             {bus.m_we, bus.owner}, bus.m_addr, bus.m_wdata);
                end
            end
            if (bus.d_done) begin got = 1; break; end
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        mem_ref[32'h100] = 32'h12345678;
        tick();
        checks++;
        if (!got) begin errors++; $display("FAIL dbg_write_done got 0 want 1"); end
        checks++;
        if (bus.d_rdata !== prev) begin errors++; $display("FAIL dbg_write_rdata got %h want %h", bus.d_rdata, prev); end
        checks++;
        if (phys[32'h100] !== 32'h12345678) begin errors++; $display("FAIL dbg_write_mem got %h want 12345678", phys[32'h100]); end
    endtask

    task automatic test_hold_done();
        bit got = 0;
        lat_min = 1; lat_max = 1;
        bus.c_we = 1'b0; bus.c_addr = 32'h40; bus.c_req = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (bus.c_done) got = 1;
        end
        tick();
        checks++;
        if (!got || bus.m_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_done_reissue got done=%0d m_req=%b want done=1 m_req=0", got, bus.m_req);
        end
        bus.c_req = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int cd = 0;
        int dd = 0;
        bit dropped = 0;
        logic [5:0] seq = 6'bx;
        do_reset();
        own_log.delete();
        lat_min = 1; lat_max = 3;
        bus.c_we = 1'b0; bus.c_addr = 32'h40;
        bus.d_we = 1'b0; bus.d_addr = 32'h100;
        bus.c_req = 1'b1; bus.d_req = 1'b1;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (bus.c_done) cd++;
            if (bus.d_done) dd++;
            if (!dropped && own_log.size() >= 6) begin dropped = 1; bus.c_req = 1'b0; bus.d_req = 1'b0; end
            if (dropped && cd + dd >= 6) break;
        end
        repeat (6) begin tick(); if (bus.c_done) cd++; if (bus.d_done) dd++; end
        if (own_log.size() == 6) seq = {own_log[0], own_log[1], own_log[2], own_log[3], own_log[4], own_log[5]};
        checks++;
        if (seq !== 6'b010101) begin errors++; $display("FAIL rr_order got %b (n=%0d) want 010101", seq, own_log.size()); end
        checks++;
        if (cd != 3 || dd != 3) begin errors++; $display("FAIL rr_dones got c=%0d d=%0d want 3 3", cd, dd); end
        checks++;
        if (bus.c_rdata !== 32'hDEADBEEF || bus.d_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL rr_rdata got c=%h d=%h want deadbeef 12345678", bus.c_rdata, bus.d_rdata);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        bit got = 0;
        int cyc = 0;
        lat_min = 100; lat_max = 100;
        bus.c_we = 1'b0; bus.c_addr = 32'h40; bus.c_req = 1'b1;
        for (int i = 0; i < 5 && !bus.m_req; i++) tick();
        tick();
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.m_req !== 1'b0) begin errors++; $display("FAIL reset_mid_m_req got %b want 0", bus.m_req); end
        bus.c_req = 1'b0;
        repeat (3) begin tick(); if (bus.c_done) seen = 1; end
        reset_n = 1'b1;
        tick();
        if (bus.c_done) seen = 1;
        checks++;
        if (seen) begin errors++; $display("FAIL reset_mid_done got 1 want 0"); end
        lat_min = 2; lat_max = 2;
        bus.c_req = 1'b1;
        while (!got && cyc < 10) begin
            tick();
            cyc++;
            if (bus.c_done) got = 1;
        end
        bus.c_req = 1'b0;
        checks++;
        if (!got || cyc != 3 || bus.c_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL reset_mid_retry got done=%0d cycles=%0d rdata=%h want 1 3 deadbeef", got, cyc, bus.c_rdata);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] r_addr[2];
        logic [31:0] r_wdata[2];
        logic [31:0] r_prev[2];
        logic r_we[2];
        bit r_pend[2];
        int r_wait[2];
        int n_done = 0;
        lat_min = 1; lat_max = 4;
        for (int p = 0; p < 2; p++) begin r_pend[p] = 0; r_wait[p] = 0; r_we[p] = 0; r_addr[p] = 0; r_wdata[p] = 0; r_prev[p] = 0; end
        for (int cyc = 0; cyc < 700; cyc++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                logic dn = p == 0 ? bus.c_done : bus.d_done;
                logic [31:0] rd = p == 0 ? bus.c_rdata : bus.d_rdata;
                logic [31:0] exp;
                if (r_pend[p]) r_wait[p]++;
                if (dn) begin
                    checks++;
                    if (!r_pend[p]) begin
                        errors++;
                        $display("FAIL rand_spurious_done port=%0d got done=1 want 0", p);
                    end else begin
                        exp = r_we[p] ? r_prev[p] : ref_read(r_addr[p]);
                        if (rd !== exp) begin
                            errors++;
                            $display("FAIL rand_rdata port=%0d we=%0d addr=%h got %h want %h", p, r_we[p], r_addr[p], rd, exp);
                        end
                        if (r_we[p]) mem_ref[r_addr[p]] = r_wdata[p];
                        n_done++;
                    end
                    r_pend[p] = 0;
                end else if (r_pend[p] && r_wait[p] > 20) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_timeout port=%0d got no done after %0d cycles want <=20", p, r_wait[p]);
                    r_pend[p] = 0;
                end else if (!r_pend[p] && cyc < 600 && $urandom_range(2, 0) == 0) begin
                    int pick = int'($urandom_range(7, 0));
                    r_pend[p] = 1;
                    r_wait[p] = 0;
                    r_we[p] = 1'($urandom_range(1, 0));
                    r_addr[p] = pick == 0 ? 32'h40 : pick == 1 ? 32'h100 : 32'h200 + 32'(pick * 4);
                    r_wdata[p] = $urandom;
                    r_prev[p] = rd;
                end
            end
            bus.c_req = r_pend[0]; bus.c_we = r_we[0]; bus.c_addr = r_addr[0]; bus.c_wdata = r_wdata[0];
            bus.d_req = r_pend[1]; bus.d_we = r_we[1]; bus.d_addr = r_addr[1]; bus.d_wdata = r_wdata[1];
        end
        checks++;
        if (r_pend[0] || r_pend[1] || n_done < 20) begin
            errors++;
            $display("FAIL rand_drain got pend=%0d%0d done=%0d want pend=00 done>=20", r_pend[0], r_pend[1], n_done);
        end
    endtask

    initial begin
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        phys[32'h40] = 32'hDEADBEEF;
        mem_ref[32'h40] = 32'hDEADBEEF;
        test_reset();
        test_cpu_read();
        test_tie();
        test_dbg_write();
        test_hold_done();
        test_round_robin();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
